ex_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID-EX segment register.
- Consumes the EX-stage operands, rd and funct3 of an M-extension instruction.
- Holds the pipeline through the hazard unit with `stall` while it computes.
- Presents a registered 32-bit result with a one-cycle `done` pulse, which the EX result mux forwards to EX-MEM.

---
 rtl/ex_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide,
// one iteration per cycle, with a sign fix-up cycle and a registered single-cycle done.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d, rneg_q, rneg_d;
  logic [4:0]         rd_q, rd_d;

  // Operand decode at issue time
  logic             is_div, s1, s2, div_zero, div_ovf;
  logic [WIDTH-1:0] mag1, mag2;

  always_comb begin
    is_div   = funct3[2];
    s1       = is_div ? (~funct3[0] & op1[WIDTH-1]) : ((funct3[0] ^ funct3[1]) & op1[WIDTH-1]);
    s2       = is_div ? (~funct3[0] & op2[WIDTH-1]) : ((funct3 == 3'b001) & op2[WIDTH-1]);
    mag1     = s1 ? (~op1 + 1'b1) : op1;
    mag2     = s2 ? (~op2 + 1'b1) : op2;
    div_zero = (op2 == '0);
    div_ovf  = ~funct3[0] & (op1 == {1'b1, {(WIDTH-1){1'b0}}}) & (op2 == '1);
  end

  // Datapath for one iteration and for the final fix-up
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[WIDTH];
    prod      = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo       = neg_q ? (~a_q + 1'b1) : a_q;
    rem       = rneg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    rd_d    = rd_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            f3_d   = funct3;
            rd_d   = rd_in;
            a_d    = mag1;
            b_d    = mag2;
            acc_d  = '0;
            neg_d  = s1 ^ s2;
            rneg_d = s1;
            cnt_d  = '0;
            if (is_div && div_zero) begin
              res_d   = funct3[1] ? op1 : '1;
              state_d = StDone;
            end else if (is_div && div_ovf) begin
              res_d   = funct3[1] ? '0 : op1;
              state_d = StDone;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          if (f3_q[2]) begin
            a_d   = {a_q[WIDTH-2:0], div_ok};
            acc_d = {{WIDTH{1'b0}}, (div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0])};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          if (f3_q[2]) begin
            res_d = f3_q[1] ? rem : quo;
          end else begin
            res_d = (f3_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
          end
          cnt_d   = '0;
          state_d = StDone;
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
    end
  end

  // Gated by rst_n so a held start cannot stall the pipeline during reset
  assign stall  = rst_n & (((state_q == StIdle) & start & ~flush) |
                           (state_q == StCalc) | (state_q == StFix));
  assign done   = (state_q == StDone);
  assign result = res_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: issued ops push expected results from a 64-bit
// arithmetic reference model; a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic [4:0]  rd_in;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_issued = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op1    (op1),
    .op2    (op2),
    .rd_in  (rd_in),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] x, y;
    bit                 ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    x   = a;
    y   = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $unsigned(x / y);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : $unsigned(x % y);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Call at a negedge; returns at the negedge of the DONE cycle with start still high.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    exp_t e;
    int   stalls;
    bit   seen;
    start  = 1'b1;
    funct3 = f;
    op1    = a;
    op2    = b;
    rd_in  = rd;
    e.res  = model(f, a, b);
    e.rd   = rd;
    exp_q.push_back(e);
    n_issued++;
    stalls = 0;
    seen   = 1'b0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (stall) stalls++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("stall_cycles", stalls, is_special(f, a, b) ? 32'd1 : 32'd34);
    chk("stall_in_done", 32'(stall), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      chk("done_pulse", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("rd_out", 32'(rd_out), 32'(e.rd));
      end
    end
    prev_done = rst_n & done;
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b, held;
    rst_n  = 1'b0;
    start  = 1'b1;
    flush  = 1'b0;
    funct3 = 3'd0;
    op1    = 32'd7;
    op2    = 32'd3;
    rd_in  = 5'd1;
    #3;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed ops, start held continuously across all of them
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    issue(3'd5, 32'd100, 32'd7, 5'd6);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);
    issue(3'd7, 32'd100, 32'd7, 5'd12);
    issue(3'd5, 32'd5, 32'd0, 5'd13);
    issue(3'd6, 32'd5, 32'd0, 5'd14);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    start = 1'b0;
    @(negedge clk);

    // Randomized ops with corner-case bias and random idle gaps
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      issue(f, a, b, 5'($urandom_range(0, 31)));
      start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of CALC (counter == 10)
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    funct3 = 3'd0;
    op1    = 32'd3;
    op2    = 32'd5;
    rd_in  = 5'd3;
    @(negedge clk);
    @(negedge clk);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_stall", 32'(stall), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(3'd0, 32'd12345, 32'd678, 5'd21);
    start = 1'b0;
    @(negedge clk);

    // Flush in the middle of CALC
    issue(3'd5, 32'd100, 32'd7, 5'd4);
    held  = model(3'd5, 32'd100, 32'd7);
    start = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    op1    = 32'd11;
    op2    = 32'd13;
    rd_in  = 5'd6;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_result", result, held);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_result_hold", result, held);
    issue(3'd7, 32'd1000, 32'd33, 5'd30);
    start = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("done_count", n_done, n_issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
